ttt_game_ctrl: RTL

Game sequencer for the tic-tac-toe design; it owns the 3x3 board state that the pixel renderer draws. It accepts a cursor square and a one-shot "place" pulse, and rejects illegal moves. For each legal move it writes the mark, scans the 8 winning lines one per clock, and then either hands the turn over or declares the game finished. It sits between the input path (debounce/oneshot, rotary cursor) and the VGA renderer, which reads cells through a registered read port.

---
 rtl/ttt_pkg.sv | 37 +++
 rtl/ttt_line_check.sv | 21 ++
 rtl/ttt_game_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Holds cell codes, the FSM state type and the winning-line table.
package ttt_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;

    localparam logic [3:0] LAST_CELL = 4'd8;
    localparam logic [2:0] LAST_LINE = 3'd7;
    localparam logic [3:0] FULL_MOVES = 4'd9;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

    // Cell n lives at bits [2n+1:2n].
    typedef logic [NUM_CELLS-1:0][1:0] board_t;

    // Listed from line 7 down to line 0 (leftmost pattern element is the top index).
    localparam logic [NUM_LINES-1:0][2:0][3:0] LINE_CELLS = '{
        '{4'd2, 4'd4, 4'd6},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd5, 4'd8},
        '{4'd1, 4'd4, 4'd7},
        '{4'd0, 4'd3, 4'd6},
        '{4'd6, 4'd7, 4'd8},
        '{4'd3, 4'd4, 4'd5},
        '{4'd0, 4'd1, 4'd2}
    };

    function automatic logic [1:0] mark_of(input logic player);
        return {player, ~player};
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational test of one winning line against a mark.
// hit is high when all three cells of line_idx hold mark.
module ttt_line_check
    import ttt_pkg::*;
(
    input  board_t     board,
    input  logic [2:0] line_idx,
    input  logic [1:0] mark,
    output logic       hit
);

    always_comb begin
        hit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (board[LINE_CELLS[line_idx][i]] != mark) begin
                hit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencer: owns the board, validates moves, scans one line per
// clock after each placement and either hands over the turn or ends the game.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [3:0]  cursor,
    input  logic        enter,
    input  logic [3:0]  rd_addr,
    output logic [1:0]  rd_data,
    output logic [17:0] board,
    output logic        player_turn,
    output logic        busy,
    output logic        move_reject,
    output logic        player_win,
    output logic [1:0]  winner,
    output logic [2:0]  win_line,
    output logic        draw
);

    state_t     state_q, state_d;
    board_t     board_q, board_d;
    logic [3:0] moves_q, moves_d;
    logic [2:0] line_q, line_d;
    logic       turn_q, turn_d;
    logic       reject_q, reject_d;
    logic       win_q, win_d;
    logic [1:0] winner_q, winner_d;
    logic [2:0] win_line_q, win_line_d;
    logic       draw_q, draw_d;
    logic [1:0] rd_data_q;

    logic [1:0] mark;
    logic       line_hit;
    logic       cell_free;

    assign mark = mark_of(turn_q);
    // Guard the lookup so out-of-range cursors never read a phantom cell.
    assign cell_free = (cursor <= LAST_CELL) && (board_q[cursor] == CELL_EMPTY);

    ttt_line_check u_line_check (
        .board    (board_q),
        .line_idx (line_q),
        .mark     (mark),
        .hit      (line_hit)
    );

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        moves_d    = moves_q;
        line_d     = line_q;
        turn_d     = turn_q;
        reject_d   = 1'b0;
        win_d      = win_q;
        winner_d   = winner_q;
        win_line_d = win_line_q;
        draw_d     = draw_q;

        unique case (state_q)
            IDLE: begin
                if (enter) begin
                    if (cell_free) begin
                        board_d[cursor] = mark;
                        moves_d         = moves_q + 4'd1;
                        line_d          = 3'd0;
                        state_d         = CHECK;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (line_hit) begin
                    state_d    = OVER;
                    win_d      = 1'b1;
                    winner_d   = mark;
                    win_line_d = line_q;
                end else if (line_q == LAST_LINE) begin
                    if (moves_q == FULL_MOVES) begin
                        state_d = OVER;
                        draw_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        turn_d  = ~turn_q;
                    end
                end else begin
                    line_d = line_q + 3'd1;
                end
            end
            OVER: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q    <= IDLE;
            board_q    <= '0;
            moves_q    <= 4'd0;
            line_q     <= 3'd0;
            turn_q     <= FIRST_PLAYER;
            reject_q   <= 1'b0;
            win_q      <= 1'b0;
            winner_q   <= CELL_EMPTY;
            win_line_q <= 3'd0;
            draw_q     <= 1'b0;
            rd_data_q  <= CELL_EMPTY;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            moves_q    <= moves_d;
            line_q     <= line_d;
            turn_q     <= turn_d;
            reject_q   <= reject_d;
            win_q      <= win_d;
            winner_q   <= winner_d;
            win_line_q <= win_line_d;
            draw_q     <= draw_d;
            rd_data_q  <= (rd_addr <= LAST_CELL) ? board_q[rd_addr] : CELL_EMPTY;
        end
    end

    assign rd_data     = rd_data_q;
    assign board       = board_q;
    assign player_turn = turn_q;
    assign busy        = (state_q == CHECK);
    assign move_reject = reject_q;
    assign player_win  = win_q;
    assign winner      = winner_q;
    assign win_line    = win_line_q;
    assign draw        = draw_q;

endmodule
